// File: rtl/u_block_sum_generator_pkg.sv
// -----------------------------------------------------------------------------
// u_block_sum_generator_pkg
// Shared constants, types and small arithmetic helpers for the 2x2 block-sum
// generator and its line RAMs.
//   H_ACTIVE / V_ACTIVE : default raster geometry (pixels per line, lines).
//   SUM_W               : width of a 2x2 block sum (8-bit pixels + 2).
//   BLK_COLS / BLK_AW   : block columns per line and their address width.
//   COL_W / ROW_W       : widths of the column and row counters.
// -----------------------------------------------------------------------------
package u_block_sum_generator_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int SUM_W    = 10;

   localparam int PIX_W    = 8;
   localparam int HALF_W   = PIX_W + 1;      // sum of two horizontal pixels
   localparam int BLK_COLS = H_ACTIVE / 2;
   localparam int BLK_AW   = 9;
   localparam int COL_W    = 10;
   localparam int ROW_W    = 9;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [HALF_W-1:0] half_t;
   typedef logic [SUM_W-1:0]  sum_t;

   // Horizontal pair sum, widened by one bit so 255+255 cannot wrap.
   function automatic half_t pair_add(input pix_t a, input pix_t b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Vertical combination of two pair sums into a full 2x2 block sum.
   function automatic sum_t block_add(input half_t a, input half_t b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/u_block_line_ram.sv
// -----------------------------------------------------------------------------
// u_block_line_ram
// One line of per-block storage: single write port and a registered read
// port. Contents are never reset, so it maps onto block or distributed RAM;
// the user tracks validity separately.
// Ports:
//   clk   : system clock
//   we    : write enable, waddr/wdata written on the rising edge
//   waddr : write address (block column)
//   wdata : write data
//   re    : read enable; rdata updates only when re is high
//   raddr : read address, sampled with re
//   rdata : registered read data, holds while re is low
// -----------------------------------------------------------------------------
module u_block_line_ram
   import u_block_sum_generator_pkg::*;
#(
   parameter int DATA_W = HALF_W,
   parameter int DEPTH  = BLK_COLS,
   parameter int ADDR_W = BLK_AW
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Write port: one entry per enabled clock.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; the held value lets the reader stall freely.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/u_block_sum_generator.sv
// -----------------------------------------------------------------------------
// u_block_sum_generator
// Forms 2x2 block sums of a ce-qualified grayscale raster. The sum of line
// pair (2j, 2j+1) is presented on average_value during the following even
// line, held across block columns 2k and 2k+1. Odd lines hold the last value.
// Ports:
//   clk           : system clock
//   rst           : synchronous active-low reset
//   ce            : pixel strobe, one gray_int pixel accepted per clk with ce
//   gray_int      : 8-bit grayscale pixel
//   average_value : block sum of the previous line pair for the current block
//   block_valid   : set once the first full line pair has been summed
//   col_cnt       : column of the next pixel to be accepted
//   row_cnt       : row of the next pixel to be accepted
// Storage:
//   A : per-block horizontal pair sums of the current even line (9 bit)
//   B : per-block 2x2 sums of the last completed line pair (10 bit)
// -----------------------------------------------------------------------------
module u_block_sum_generator
   import u_block_sum_generator_pkg::*;
#(
   parameter int H_ACTIVE = u_block_sum_generator_pkg::H_ACTIVE,
   parameter int V_ACTIVE = u_block_sum_generator_pkg::V_ACTIVE,
   parameter int SUM_W    = u_block_sum_generator_pkg::SUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [7:0]       gray_int,
   output logic [SUM_W-1:0] average_value,
   output logic             block_valid,
   output logic [9:0]       col_cnt,
   output logic [8:0]       row_cnt
);

   localparam int BLK_N = H_ACTIVE / 2;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_ACTIVE - 1);
   localparam logic [BLK_AW-1:0] BLK_LAST = BLK_AW'(BLK_N - 1);

   // Pairing FSM: left pixel of a horizontal pair, then right pixel.
   localparam logic [0:0] PH_LEFT  = 1'b0;
   localparam logic [0:0] PH_RIGHT = 1'b1;

   logic [COL_W-1:0]  col_r;
   logic [COL_W-1:0]  col_nxt_s;
   logic [ROW_W-1:0]  row_r;
   logic [ROW_W-1:0]  row_nxt_s;
   logic [0:0]        phase_r;
   logic [0:0]        phase_nxt_s;
   logic [PIX_W-1:0]  pair_r;
   logic [SUM_W-1:0]  avg_r;
   logic              blk_valid_r;

   logic              col_last_s;
   logic              row_last_s;
   logic              row_odd_s;
   logic              blk_last_s;
   logic              left_ce_s;
   logic              right_ce_s;
   logic [BLK_AW-1:0] blk_idx_s;
   half_t             h_sum_s;

   logic              a_we_s;
   logic              a_re_s;
   logic [HALF_W-1:0] a_rdata_s;

   logic              b_we_s;
   logic              b_re_s;
   logic [BLK_AW-1:0] b_raddr_s;
   logic [SUM_W-1:0]  b_wdata_s;
   logic [SUM_W-1:0]  b_rdata_s;

   logic              pair_done_s;
   logic              avg_load_s;
   logic [SUM_W-1:0]  avg_nxt_s;

   // Position decode and horizontal pair sum.
   always_comb begin
      col_last_s = (col_r == COL_LAST);
      row_last_s = (row_r == ROW_LAST);
      row_odd_s  = row_r[0];
      blk_idx_s  = col_r[COL_W-1:1];
      blk_last_s = (blk_idx_s == BLK_LAST);
      left_ce_s  = ce & (phase_r == PH_LEFT);
      right_ce_s = ce & (phase_r == PH_RIGHT);
      h_sum_s    = pair_add(pair_r, gray_int);
   end

   // Pairing FSM next state: each accepted pixel toggles the pair phase.
   always_comb begin
      case (phase_r)
         PH_LEFT: begin
            if (ce) begin
               phase_nxt_s = PH_RIGHT;
            end else begin
               phase_nxt_s = PH_LEFT;
            end
         end
         PH_RIGHT: begin
            if (ce) begin
               phase_nxt_s = PH_LEFT;
            end else begin
               phase_nxt_s = PH_RIGHT;
            end
         end
         default: phase_nxt_s = PH_LEFT;
      endcase
   end

   // Raster counters: column wraps into the row, row wraps into the frame.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (ce) begin
         if (col_last_s) begin
            col_nxt_s = {COL_W{1'b0}};
            if (row_last_s) begin
               row_nxt_s = {ROW_W{1'b0}};
            end else begin
               row_nxt_s = row_r + ROW_W'(1'b1);
            end
         end else begin
            col_nxt_s = col_r + COL_W'(1'b1);
            row_nxt_s = row_r;
         end
      end else begin
         col_nxt_s = col_r;
         row_nxt_s = row_r;
      end
   end

   // RAM control. Even lines fill A; odd lines read A one pixel ahead (at
   // the left pixel) so A[k] is ready when the right pixel completes B[k].
   always_comb begin
      a_we_s    = right_ce_s & ~row_odd_s;
      a_re_s    = left_ce_s & row_odd_s;
      b_we_s    = right_ce_s & row_odd_s;
      b_wdata_s = block_add(a_rdata_s, h_sum_s);
      if (row_odd_s) begin
         // Last left pixel of the odd line prefetches B[0] for the next line.
         b_re_s    = left_ce_s & blk_last_s;
         b_raddr_s = {BLK_AW{1'b0}};
      end else begin
         // Even lines prefetch the next block; nothing to fetch after the last.
         b_re_s    = left_ce_s & ~blk_last_s;
         b_raddr_s = blk_idx_s + BLK_AW'(1'b1);
      end
   end

   // Output load: next block on each right pixel of an even line, and B[0]
   // when the odd line completes. B is masked until a pair has completed.
   always_comb begin
      pair_done_s = right_ce_s & row_odd_s & col_last_s;
      if (row_odd_s) begin
         avg_load_s = pair_done_s;
      end else begin
         avg_load_s = right_ce_s & ~blk_last_s;
      end
      if (blk_valid_r | pair_done_s) begin
         avg_nxt_s = b_rdata_s;
      end else begin
         avg_nxt_s = {SUM_W{1'b0}};
      end
   end

   // State registers: counters, pair phase, half-pair, output and valid flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_r       <= {COL_W{1'b0}};
         row_r       <= {ROW_W{1'b0}};
         phase_r     <= PH_LEFT;
         pair_r      <= {PIX_W{1'b0}};
         avg_r       <= {SUM_W{1'b0}};
         blk_valid_r <= 1'b0;
      end else begin
         col_r   <= col_nxt_s;
         row_r   <= row_nxt_s;
         phase_r <= phase_nxt_s;
         if (left_ce_s) begin
            pair_r <= gray_int;
         end
         if (avg_load_s) begin
            avg_r <= avg_nxt_s;
         end
         if (pair_done_s) begin
            blk_valid_r <= 1'b1;
         end
      end
   end

   u_block_line_ram #(
      .DATA_W (HALF_W),
      .DEPTH  (BLK_N),
      .ADDR_W (BLK_AW)
   ) u_ram_a (
      .clk   (clk),
      .we    (a_we_s),
      .waddr (blk_idx_s),
      .wdata (h_sum_s),
      .re    (a_re_s),
      .raddr (blk_idx_s),
      .rdata (a_rdata_s)
   );

   u_block_line_ram #(
      .DATA_W (SUM_W),
      .DEPTH  (BLK_N),
      .ADDR_W (BLK_AW)
   ) u_ram_b (
      .clk   (clk),
      .we    (b_we_s),
      .waddr (blk_idx_s),
      .wdata (b_wdata_s),
      .re    (b_re_s),
      .raddr (b_raddr_s),
      .rdata (b_rdata_s)
   );

   assign average_value = avg_r;
   assign block_valid   = blk_valid_r;
   assign col_cnt       = col_r;
   assign row_cnt       = row_r;

endmodule
